// File: rtl/baud_pkg.sv
// Shared constants and types for the baud tick generator (optional fractional
// divisor enabled by defining BAUD_FRAC_EN).
package baud_pkg;

  localparam int unsigned OS_DEF     = 16;
  localparam int unsigned MIN_DIV    = 2;
  localparam int unsigned DIV_W_DEF  = 16;
  localparam int unsigned FRAC_W_DEF = 4;

  typedef logic [$clog2(OS_DEF)-1:0] phase_t;

endpackage

// File: rtl/baud_prescaler.sv
// Oversample prescaler: clamps the divisor, counts CLKIN cycles and emits os_tick.
// Defining BAUD_FRAC_EN adds the frac input and fractional accumulator.
module baud_prescaler
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
`ifdef BAUD_FRAC_EN
  ,
  parameter int unsigned FRAC_W = FRAC_W_DEF
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             resync_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] frac_i,
`endif
  output logic             wrap_o,
  output logic             os_tick_o
);

  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic [DIV_W-1:0] div_clamped;
  logic [DIV_W-1:0] term_cnt;
  logic             os_tick_q, os_tick_d;
  logic             wrap;

  assign div_clamped = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] facc_q, facc_d;
  logic              carry_q, carry_d;

  // A pending carry stretches the current period by one cycle.
  assign term_cnt = div_clamped - DIV_W'(1) + DIV_W'(carry_q);
`else
  assign term_cnt = div_clamped - DIV_W'(1);
`endif

  // >= so that lowering div below the running count wraps on the next edge.
  assign wrap = en_i && !resync_i && (pcnt_q >= term_cnt);

  always_comb begin
    pcnt_d    = pcnt_q;
    os_tick_d = 1'b0;
`ifdef BAUD_FRAC_EN
    facc_d    = facc_q;
    carry_d   = carry_q;
`endif
    if (resync_i) begin
      pcnt_d  = '0;
`ifdef BAUD_FRAC_EN
      facc_d  = '0;
      carry_d = 1'b0;
`endif
    end else if (en_i) begin
      if (wrap) begin
        pcnt_d    = '0;
        os_tick_d = 1'b1;
`ifdef BAUD_FRAC_EN
        {carry_d, facc_d} = {1'b0, facc_q} + {1'b0, frac_i};
`endif
      end else begin
        pcnt_d = pcnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt_q    <= '0;
      os_tick_q <= 1'b0;
`ifdef BAUD_FRAC_EN
      facc_q    <= '0;
      carry_q   <= 1'b0;
`endif
    end else begin
      pcnt_q    <= pcnt_d;
      os_tick_q <= os_tick_d;
`ifdef BAUD_FRAC_EN
      facc_q    <= facc_d;
      carry_q   <= carry_d;
`endif
    end
  end

  assign wrap_o    = wrap;
  assign os_tick_o = os_tick_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator top: oversample phase counter plus bit/mid-bit ticks.
// Defining BAUD_FRAC_EN enables the fractional divisor and the frac port.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned OS     = OS_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic                  CLKIN,
  input  logic                  RESET,
  input  logic                  en,
  input  logic [DIV_W-1:0]      div,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0]     frac,
`endif
  input  logic                  resync,
  output logic                  os_tick,
  output logic                  bit_tick,
  output logic                  mid_tick,
  output logic [$clog2(OS)-1:0] phase
);

  localparam int unsigned PhW = $clog2(OS);

  if ((OS < 4) || ((OS & (OS - 1)) != 0)) begin : g_bad_os
    $error("baud_tick_gen: OS must be a power of two >= 4");
  end
  if (FRAC_W == 0) begin : g_bad_frac
    $error("baud_tick_gen: FRAC_W must be at least 1");
  end

  logic           wrap;
  logic [PhW-1:0] ph_q, ph_d;
  logic           bit_tick_q, bit_tick_d;
  logic           mid_tick_q, mid_tick_d;

  baud_prescaler #(
    .DIV_W    (DIV_W)
`ifdef BAUD_FRAC_EN
    ,
    .FRAC_W   (FRAC_W)
`endif
  ) u_prescaler (
    .clk_i    (CLKIN),
    .rst_i    (RESET),
    .en_i     (en),
    .resync_i (resync),
    .div_i    (div),
`ifdef BAUD_FRAC_EN
    .frac_i   (frac),
`endif
    .wrap_o   (wrap),
    .os_tick_o(os_tick)
  );

  // wrap already excludes resync and en=0, so ticks stay aligned with os_tick.
  always_comb begin
    ph_d       = ph_q;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    if (resync) begin
      ph_d = '0;
    end else if (wrap) begin
      ph_d       = ph_q + PhW'(1);
      bit_tick_d = (ph_q == PhW'(OS - 1));
      mid_tick_d = (ph_q == PhW'(OS / 2 - 1));
    end
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      ph_q       <= '0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign phase    = ph_q;

endmodule
